// File: rtl/conv_win.sv
// 4x4 sliding-window assembler fed by the line-buffer column stream.
// Tracks raster position and flags windows that lie fully inside the frame.
package conv_pkg;
    typedef logic [7:0] pixel_t;
endpackage

module conv_win #(
    parameter  int IMG_W = 64,
    parameter  int IMG_H = 64,
    localparam int X_W   = $clog2(IMG_W),
    localparam int Y_W   = $clog2(IMG_H)
) (
    input  logic                              clk,
    input  logic                              arst_n,
    input  logic                              push_i,
    input  logic                              sof_i,
    input  conv_pkg::pixel_t                  colA_i,
    input  conv_pkg::pixel_t                  colB_i,
    input  conv_pkg::pixel_t                  colC_i,
    input  conv_pkg::pixel_t                  colD_i,
    output logic                              win_vld_o,
    output conv_pkg::pixel_t [3:0][3:0]       win_o,
    output logic [X_W-1:0]                    win_x_o,
    output logic [Y_W-1:0]                    win_y_o,
    output logic                              eof_o,
    output logic                              frame_err_o
);

    localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

    logic [X_W-1:0] x_q, x_d, px, wx_q, wx_d;
    logic [Y_W-1:0] y_q, y_d, py, wy_q, wy_d;
    conv_pkg::pixel_t [3:0][3:0] win_q, win_d;
    conv_pkg::pixel_t [3:0]      col;
    logic vld_q, vld_d, eof_q, eof_d, err_q, err_d;

    assign col = {colD_i, colC_i, colB_i, colA_i};

    always_comb begin
        x_d   = x_q;
        y_d   = y_q;
        win_d = win_q;
        wx_d  = wx_q;
        wy_d  = wy_q;
        vld_d = 1'b0;
        eof_d = 1'b0;
        err_d = 1'b0;
        // sof forces the column to (0,0) regardless of where the counters were
        px    = sof_i ? '0 : x_q;
        py    = sof_i ? '0 : y_q;
        if (push_i) begin
            err_d = sof_i && ((x_q != '0) || (y_q != '0));
            for (int unsigned r = 0; r < 4; r++) begin
                win_d[r][2:0] = win_q[r][3:1];
                win_d[r][3]   = col[r];
            end
            if (px != X_LAST) begin
                x_d = px + X_W'(1);
                y_d = py;
            end else begin
                x_d = '0;
                if (py != Y_LAST) begin
                    y_d = py + Y_W'(1);
                end else begin
                    y_d   = '0;
                    eof_d = 1'b1;
                end
            end
            if ((px >= X_W'(3)) && (py >= Y_W'(3))) begin
                vld_d = 1'b1;
                wx_d  = px - X_W'(3);
                wy_d  = py - Y_W'(3);
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            x_q   <= '0;
            y_q   <= '0;
            win_q <= '0;
            wx_q  <= '0;
            wy_q  <= '0;
            vld_q <= 1'b0;
            eof_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            win_q <= win_d;
            wx_q  <= wx_d;
            wy_q  <= wy_d;
            vld_q <= vld_d;
            eof_q <= eof_d;
            err_q <= err_d;
        end
    end

    assign win_vld_o   = vld_q;
    assign win_o       = win_q;
    assign win_x_o     = wx_q;
    assign win_y_o     = wy_q;
    assign eof_o       = eof_q;
    assign frame_err_o = err_q;

endmodule

// File: tb/tb_conv_win.sv
// Scoreboard bench for conv_win: two instances (8x6 and 4x4) driven by a
// raster-position model whose expected events are checked by a negedge monitor.
module tb_conv_win;
    typedef conv_pkg::pixel_t pixel_t;
    typedef pixel_t [3:0]      col_t;
    typedef pixel_t [3:0][3:0] win_t;

    typedef struct {
        int   d;
        int   kind;   // 0 window, 1 eof, 2 frame error
        int   stamp;
        int   x;
        int   y;
        win_t w;
    } ev_t;

    typedef struct {
        int   d;
        col_t c;
    } log_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic   arst_n;
    logic   push [2];
    logic   sof  [2];
    col_t   col  [2];
    logic   vld  [2];
    logic   eof  [2];
    logic   err  [2];
    win_t   win  [2];
    logic [2:0] x0, y0;
    logic [1:0] x1, y1;

    conv_win #(.IMG_W(8), .IMG_H(6)) u_dut0 (
        .clk(clk), .arst_n(arst_n), .push_i(push[0]), .sof_i(sof[0]),
        .colA_i(col[0][0]), .colB_i(col[0][1]), .colC_i(col[0][2]), .colD_i(col[0][3]),
        .win_vld_o(vld[0]), .win_o(win[0]), .win_x_o(x0), .win_y_o(y0),
        .eof_o(eof[0]), .frame_err_o(err[0])
    );

    conv_win #(.IMG_W(4), .IMG_H(4)) u_dut1 (
        .clk(clk), .arst_n(arst_n), .push_i(push[1]), .sof_i(sof[1]),
        .colA_i(col[1][0]), .colB_i(col[1][1]), .colC_i(col[1][2]), .colD_i(col[1][3]),
        .win_vld_o(vld[1]), .win_o(win[1]), .win_x_o(x1), .win_y_o(y1),
        .eof_o(eof[1]), .frame_err_o(err[1])
    );

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ev_t  evq  [$];
    log_t clog [$];
    int   mx [2];
    int   my [2];
    int   IW [2] = '{8, 4};
    int   IH [2] = '{6, 4};
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h, expected %0h", nm, cyc, act, exp);
        end
    endtask

    // Expected window = the last four columns pushed into this instance since reset.
    function automatic win_t window_of(input int d);
        win_t w;
        int   c;
        w = '0;
        c = 3;
        for (int i = clog.size() - 1; i >= 0 && c >= 0; i--) begin
            if (clog[i].d == d) begin
                for (int r = 0; r < 4; r++) w[r][c] = clog[i].c[r];
                c--;
            end
        end
        return w;
    endfunction

    task automatic model_push(input int d, input bit s, input col_t c);
        int px, py, idx, stamp;
        ev_t e;
        stamp = cyc + 1;
        px = s ? 0 : mx[d];
        py = s ? 0 : my[d];
        if (s && (mx[d] != 0 || my[d] != 0))
            evq.push_back('{d: d, kind: 2, stamp: stamp, x: 0, y: 0, w: '0});
        clog.push_back('{d: d, c: c});
        if (px >= 3 && py >= 3) begin
            e = '{d: d, kind: 0, stamp: stamp, x: px - 3, y: py - 3, w: window_of(d)};
            evq.push_back(e);
        end
        idx = py * IW[d] + px + 1;
        if (idx == IW[d] * IH[d]) begin
            evq.push_back('{d: d, kind: 1, stamp: stamp, x: 0, y: 0, w: '0});
            idx = 0;
        end
        mx[d] = idx % IW[d];
        my[d] = idx / IW[d];
    endtask

    function automatic col_t rcol();
        return col_t'($urandom);
    endfunction

    // Idle instance sees random sof/data with push low, which must be ignored.
    task automatic step(input int d, input bit p, input bit s, input col_t c);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            push[k] = 1'b0;
            sof[k]  = ($urandom_range(0, 3) == 0);
            col[k]  = rcol();
        end
        push[d] = p;
        sof[d]  = s;
        col[d]  = c;
        if (p) model_push(d, s, c);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        arst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push[k] = 1'b0;
            sof[k]  = 1'b0;
            mx[k]   = 0;
            my[k]   = 0;
        end
        evq.delete();
        clog.delete();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1;
        arst_n = 1'b1;
    endtask

    function automatic col_t tag(input int x, input int y);
        col_t c;
        for (int r = 0; r < 4; r++) c[r] = {4'(y - 3 + r), 4'(x)};
        return c;
    endfunction

    int   hx [2];
    int   hy [2];
    int   idx;
    bit   e;
    logic a;
    logic [7:0] ax, ay;

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            ax = (d == 0) ? 8'(x0) : 8'(x1);
            ay = (d == 0) ? 8'(y0) : 8'(y1);
            if (!arst_n) begin
                hx[d] = 0;
                hy[d] = 0;
                chk($sformatf("reset_outputs_d%0d", d),
                    160'({vld[d], eof[d], err[d], ax, ay, win[d]}), 160'(0));
            end else begin
                for (int k = 0; k < 3; k++) begin
                    idx = -1;
                    for (int i = 0; i < evq.size(); i++)
                        if (idx < 0 && evq[i].d == d && evq[i].kind == k) idx = i;
                    e = (idx >= 0) && (evq[idx].stamp == cyc);
                    a = (k == 0) ? vld[d] : (k == 1) ? eof[d] : err[d];
                    chk($sformatf("%s_d%0d", (k == 0) ? "win_vld" : (k == 1) ? "eof" : "frame_err", d),
                        160'(a), 160'(e));
                    if (e) begin
                        if (k == 0) begin
                            chk($sformatf("win_data_d%0d", d), 160'(win[d]), 160'(evq[idx].w));
                            hx[d] = evq[idx].x;
                            hy[d] = evq[idx].y;
                        end
                        evq.delete(idx);
                    end
                end
                chk($sformatf("win_x_d%0d", d), 160'(ax), 160'(hx[d]));
                chk($sformatf("win_y_d%0d", d), 160'(ay), 160'(hy[d]));
            end
        end
    end

    initial begin
        int n;
        arst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            push[k] = 1'b0;
            sof[k]  = 1'b0;
            col[k]  = '0;
            mx[k]   = 0;
            my[k]   = 0;
        end
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1;
        arst_n = 1'b1;

        // 4x4 single frame with {y,x} tags
        for (int i = 0; i < 16; i++) step(1, 1'b1, i == 0, tag(i % 4, i / 4));
        repeat (3) step(1, 1'b0, 1'b0, '0);

        // 4x4 back-to-back frames
        for (int i = 0; i < 32; i++) step(1, 1'b1, (i % 16) == 0, tag(i % 4, (i / 4) % 4));
        repeat (3) step(1, 1'b0, 1'b0, '0);

        // 8x6 full frame with ~30% idle gaps
        n = 0;
        while (n < 48) begin
            if ($urandom_range(0, 99) < 30) step(0, 1'b0, 1'b0, rcol());
            else begin
                step(0, 1'b1, n == 0, rcol());
                n++;
            end
        end
        repeat (3) step(0, 1'b0, 1'b0, '0);

        // sof mid-frame at (5,3), then finish the restarted frame
        for (int i = 0; i < 29; i++) step(0, 1'b1, i == 0, rcol());
        step(0, 1'b1, 1'b1, rcol());
        for (int i = 0; i < 47; i++) step(0, 1'b1, 1'b0, rcol());
        repeat (3) step(0, 1'b0, 1'b0, '0);

        // reset at (6,4), then a frame counted from (0,0) without sof, then one with sof
        for (int i = 0; i < 38; i++) step(0, 1'b1, i == 0, rcol());
        do_reset();
        for (int i = 0; i < 48; i++) step(0, 1'b1, 1'b0, rcol());
        n = 0;
        while (n < 48) begin
            if ($urandom_range(0, 99) < 30) step(0, 1'b0, 1'b0, rcol());
            else begin
                step(0, 1'b1, n == 0, rcol());
                n++;
            end
        end
        repeat (4) step(0, 1'b0, 1'b0, '0);

        @(negedge clk);
        chk("events_drained", 160'(evq.size()), 160'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
